// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-0 master: FSM states, mode constants, width helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SCK_HIGH,
    SCK_LOW,
    HOLD,
    DESELECT
  } state_t;

  // Mode 0: sck idles low, data is sampled on the rising edge.
  localparam logic SPI_MODE0_CPOL = 1'b0;
  localparam logic SPI_MODE0_CPHA = 1'b0;

  // Ceiling log2, used to size counters that must hold the value itself.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_clk_divider.sv
// Half-period tick generator: one-cycle tick every HALF_PERIOD clk cycles while run=1.
// Latency: first tick HALF_PERIOD cycles after run rises; counter restarts at 0 when run falls.
// Backpressure: none; run is the only control.
module spi_clk_divider
  import spi_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CW = clog2(HALF_PERIOD + 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == CW'(HALF_PERIOD - 1));

  // Count cycles within a phase; wrap on every tick so each phase starts at 0.
  always_ff @(posedge clk) begin
    if (reset || !run || tick) cnt <= '0;
    else                       cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one DATA_WIDTH word per transaction, MSB first, sck from a clk divider.
// Latency: rx_valid HALF_PERIOD*(2*DATA_WIDTH+2) cycles after acceptance; idle again after HALF_PERIOD*(2*DATA_WIDTH+3).
// Backpressure: tx_ready only in IDLE; tx_valid without tx_ready is dropped, not queued.
// Optional: define SPI_MASTER_SDI_SYNC_EN to pass sdi through a 2-flop synchronizer (needs HALF_PERIOD>=3).
module spi_master
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int HALF_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  sck,
  output logic                  sdo,
  input  logic                  sdi,
  output logic                  cs_n
);

  localparam int BW = clog2(DATA_WIDTH + 1);

  generate
    if (HALF_PERIOD < 1) begin : g_hp_check
      $error("spi_master: HALF_PERIOD must be at least 1");
    end
    if (DATA_WIDTH < 2) begin : g_dw_check
      $error("spi_master: DATA_WIDTH must be at least 2");
    end
`ifdef SPI_MASTER_SDI_SYNC_EN
    if (HALF_PERIOD < 3) begin : g_sync_check
      $error("spi_master: SDI synchronizer needs HALF_PERIOD of at least 3");
    end
`endif
  endgenerate

  state_t                state;
  state_t                next_state;
  logic                  tick;
  logic                  div_run;
  logic                  accept;
  logic                  sdi_sample;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic [BW-1:0]         bit_cnt;

  assign accept  = tx_valid && tx_ready;
  assign div_run = (state != IDLE);
  // Zeros shift in behind the data, so sdo naturally returns to 0 by IDLE.
  assign sdo     = tx_sr[DATA_WIDTH-1];

`ifdef SPI_MASTER_SDI_SYNC_EN
  logic [1:0] sdi_sync;

  // Two-flop synchronizer; the sample point stays put, so data is two cycles older.
  always_ff @(posedge clk) begin
    if (reset) sdi_sync <= '0;
    else       sdi_sync <= {sdi_sync[0], sdi};
  end

  assign sdi_sample = sdi_sync[1];
`else
  assign sdi_sample = sdi;
`endif

  spi_clk_divider #(
    .HALF_PERIOD(HALF_PERIOD)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .run   (div_run),
    .tick  (tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Phase sequencing: every non-idle phase lasts exactly one divider tick.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (accept) next_state = SETUP;
      SETUP:    if (tick) next_state = SCK_HIGH;
      SCK_HIGH: if (tick) next_state = SCK_LOW;
      SCK_LOW:  if (tick) next_state = (bit_cnt == BW'(DATA_WIDTH)) ? HOLD : SCK_HIGH;
      HOLD:     if (tick) next_state = DESELECT;
      DESELECT: if (tick) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Shift registers, bit count and the received-word pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_sr    <= '0;
      rx_sr    <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (state == IDLE && accept) begin
        tx_sr   <= tx_data;
        bit_cnt <= '0;
      end
      // End of the high phase: capture sdi and move sdo on the falling sck edge.
      if (state == SCK_HIGH && tick) begin
        rx_sr   <= {rx_sr[DATA_WIDTH-2:0], sdi_sample};
        tx_sr   <= {tx_sr[DATA_WIDTH-2:0], 1'b0};
        bit_cnt <= bit_cnt + BW'(1);
      end
      if (state == HOLD && tick) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end
    end
  end

  // Pin-level outputs registered from the next state so they track the state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_ready <= 1'b0;
      cs_n     <= 1'b1;
      sck      <= SPI_MODE0_CPOL;
    end else begin
      tx_ready <= (next_state == IDLE);
      cs_n     <= (next_state == IDLE) || (next_state == DESELECT);
      sck      <= (next_state == SCK_HIGH) ^ SPI_MODE0_CPOL;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: directed and random transfers against a protocol-level model.
// Latency: expectations derived from phase counts (HALF_PERIOD per phase, 2*DATA_WIDTH+3 phases).
// Backpressure: tx_valid held until acceptance is observed; back-to-back case keeps it high.
module tb_spi_master;

  localparam int W = 8;
`ifdef SPI_MASTER_SDI_SYNC_EN
  localparam int H = 3;
`else
  localparam int H = 2;
`endif

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic [W-1:0] tx_data  = '0;
  logic         tx_valid = 1'b0;
  logic         tx_ready;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         sck;
  logic         sdo;
  logic         sdi;
  logic         cs_n;

  // Target model: loopback, or a shift register loaded on cs_n fall and shifted on sck fall.
  logic         loopback = 1'b1;
  logic [W-1:0] tgt_word = '0;
  logic [W-1:0] tgt_sr   = '0;
  assign sdi = loopback ? sdo : tgt_sr[W-1];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int           acc_q[$];
  int           rx_cyc_q[$];
  logic [W-1:0] rx_dat_q[$];
  int           rise_q[$];
  int           fall_q[$];
  logic         sdo_q[$];
  int           gap_q[$];
  int           hi_run   = 0;
  logic         sck_prev = 1'b0;
  logic         cs_prev  = 1'b1;

  spi_master #(
    .DATA_WIDTH  (W),
    .HALF_PERIOD (H)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .sck      (sck),
    .sdo      (sdo),
    .sdi      (sdi),
    .cs_n     (cs_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and target, sampled mid-cycle; cyc identifies the edge that produced each value.
  always @(negedge clk) begin
    if (tx_valid && tx_ready) acc_q.push_back(cyc + 1);
    if (rx_valid) begin
      rx_cyc_q.push_back(cyc);
      rx_dat_q.push_back(rx_data);
    end
    if (sck && !sck_prev) begin
      rise_q.push_back(cyc);
      sdo_q.push_back(sdo);
    end
    if (!sck && sck_prev) begin
      fall_q.push_back(cyc);
      tgt_sr = {tgt_sr[W-2:0], 1'b0};
    end
    if (!cs_n && cs_prev) begin
      gap_q.push_back(hi_run);
      tgt_sr = tgt_word;
    end
    hi_run   = cs_n ? hi_run + 1 : 0;
    sck_prev = sck;
    cs_prev  = cs_n;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_mon();
    acc_q.delete();
    rx_cyc_q.delete();
    rx_dat_q.delete();
    rise_q.delete();
    fall_q.delete();
    sdo_q.delete();
    gap_q.delete();
  endtask

  task automatic wait_acc(input string tag, input int n);
    int b;
    b = 0;
    while (acc_q.size() < n && b < 200) begin
      step();
      b++;
    end
    check({tag, "_accept_timeout"}, 32'(acc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_rx(input string tag, input int n);
    int b;
    b = 0;
    while (rx_cyc_q.size() < n && b < 400) begin
      step();
      b++;
    end
    check({tag, "_rx_timeout"}, 32'(rx_cyc_q.size() >= n), 32'd1);
  endtask

  task automatic wait_ready();
    int b;
    b = 0;
    while (tx_ready !== 1'b1 && b < 100) begin
      step();
      b++;
    end
  endtask

  // One complete transfer, then protocol-level checks on what the monitor recorded.
  task automatic run_xfer(input string tag, input logic [W-1:0] word,
                          input logic [W-1:0] tgt, input logic lb);
    logic [W-1:0] exp_rx;
    logic [W-1:0] sdo_word;
    int           bad;
    int           a;
    clear_mon();
    loopback = lb;
    tgt_word = tgt;
    tx_data  = word;
    tx_valid = 1'b1;
    wait_acc(tag, 1);
    tx_valid = 1'b0;
    a = acc_q[0];
    wait_rx(tag, 1);
    exp_rx = lb ? word : tgt;
    check({tag, "_rx_data"}, 32'(rx_dat_q[0]), 32'(exp_rx));
    check({tag, "_rx_latency"}, 32'(rx_cyc_q[0] - a), 32'(H * (2 * W + 2)));
    sdo_word = '0;
    for (int i = 0; i < W && i < sdo_q.size(); i++) sdo_word = {sdo_word[W-2:0], sdo_q[i]};
    check({tag, "_sdo_bits"}, 32'(sdo_word), 32'(word));
    bad = 0;
    for (int i = 0; i < W; i++) begin
      if (i < rise_q.size() && i < fall_q.size()) begin
        if (fall_q[i] - rise_q[i] != H) bad++;
        if (i + 1 < W && (i + 1 >= rise_q.size() || rise_q[i+1] - fall_q[i] != H)) bad++;
      end else begin
        bad++;
      end
    end
    check({tag, "_sck_phases"}, 32'(bad), 32'd0);
    wait_ready();
    check({tag, "_sck_rises"}, 32'(rise_q.size()), 32'(W));
    check({tag, "_ready_latency"}, 32'(cyc - a), 32'(H * (2 * W + 3)));
    check({tag, "_rx_single_pulse"}, 32'(rx_cyc_q.size()), 32'd1);
    check({tag, "_rx_hold"}, 32'(rx_data), 32'(exp_rx));
    check({tag, "_idle_sdo"}, 32'(sdo), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    logic [W-1:0] t;
    int           b;

    // Reset behaviour: held for three edges, then released.
    reset = 1'b1;
    repeat (3) begin
      step();
      check("rst_cs_n", 32'(cs_n), 32'd1);
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_tx_ready", 32'(tx_ready), 32'd0);
      check("rst_rx_valid", 32'(rx_valid), 32'd0);
    end
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_sdo", 32'(sdo), 32'd0);
    reset = 1'b0;
    step();
    check("ready_after_reset", 32'(tx_ready), 32'd1);
    check("idle_cs_n", 32'(cs_n), 32'd1);

    // Directed transfers.
    run_xfer("a5_loop", 8'hA5, 8'h00, 1'b1);
    run_xfer("ff_tgt3c", 8'hFF, 8'h3C, 1'b0);
    run_xfer("tgt_c3", 8'h00, 8'hC3, 1'b0);

    // Random transfers.
    for (int i = 0; i < 5; i++) begin
      w = W'($urandom);
      t = W'($urandom);
      run_xfer("rand", w, t, 1'($urandom_range(0, 1)));
    end

    // Back-to-back with tx_valid held high across both acceptances.
    clear_mon();
    loopback = 1'b1;
    tx_data  = 8'h01;
    tx_valid = 1'b1;
    wait_acc("b2b_first", 1);
    tx_data = 8'h80;
    wait_acc("b2b_second", 2);
    tx_valid = 1'b0;
    wait_rx("b2b", 2);
    check("b2b_rx0", 32'(rx_dat_q[0]), 32'h01);
    check("b2b_rx1", 32'(rx_dat_q[1]), 32'h80);
    check("b2b_rx_period", 32'(rx_cyc_q[1] - rx_cyc_q[0]), 32'(H * (2 * W + 3) + 1));
    check("b2b_acc_period", 32'(acc_q[1] - acc_q[0]), 32'(H * (2 * W + 3) + 1));
    check("b2b_cs_gap", 32'(gap_q[1]), 32'(H + 1));
    wait_ready();

    // Reset in the middle of a transfer, after the third sck rise.
    clear_mon();
    loopback = 1'b1;
    tx_data  = 8'hF0;
    tx_valid = 1'b1;
    wait_acc("midrst", 1);
    tx_valid = 1'b0;
    b = 0;
    while (rise_q.size() < 3 && b < 200) begin
      step();
      b++;
    end
    check("midrst_third_rise", 32'(rise_q.size()), 32'd3);
    reset = 1'b1;
    step();
    check("midrst_cs_n", 32'(cs_n), 32'd1);
    check("midrst_sck", 32'(sck), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd0);
    step();
    reset = 1'b0;
    repeat (60) step();
    check("midrst_no_rx_valid", 32'(rx_cyc_q.size()), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    check("midrst_ready", 32'(tx_ready), 32'd1);
    run_xfer("post_rst", 8'h5A, 8'h00, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
